// File: rtl/spi_slave_txd_if.sv
// Local-side byte stream for spi_slave_txd. The producer uses the master modport
// and the transmitter uses the slave modport.
interface spi_slave_txd_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_underrun;

    modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_underrun);
    modport slave  (input tx_data, tx_valid, output tx_ready, tx_done, tx_underrun);
endinterface

// File: rtl/spi_slave_txd.sv
// SPI mode-0 slave transmitter: MSB-first MISO fed from a one-deep valid/ready buffer.
// Define SPI_TXD_HIZ_EN to tri-state MISO outside an active frame.
module spi_slave_txd #(
    parameter logic [7:0] IDLE_FILL = 8'hFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_cs,
    input  logic             spi_sck,
    output logic             spi_miso,
    output logic             busy,
    spi_slave_txd_if.slave   tx
);
    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t     r_state;
    logic [1:0] r_cs_sync;   // [0] first stage, [1] second stage
    logic [1:0] r_sck_sync;
    logic [7:0] r_buf;
    logic       r_buf_full;
    logic [7:0] r_shreg;
    logic [3:0] r_bitcnt;
    logic       r_done_pend;
    logic       r_tx_done;
    logic       r_underrun;
    logic       r_miso;

    logic       w_cs_neg, w_cs_flag, w_sck_pos, w_sck_neg;
    logic       w_hs, w_load;
    logic [7:0] w_load_byte;

    assign w_cs_neg  = r_cs_sync[1] & ~r_cs_sync[0];
    assign w_cs_flag = r_cs_sync[1];
    assign w_sck_pos = ~r_sck_sync[1] & r_sck_sync[0];
    assign w_sck_neg = r_sck_sync[1] & ~r_sck_sync[0];

    assign w_hs        = tx.tx_valid & ~r_buf_full;
    assign w_load      = ((r_state == S_IDLE) & w_cs_neg) |
                         ((r_state == S_SHIFT) & ~w_cs_flag & w_sck_neg & (r_bitcnt == 4'd8));
    assign w_load_byte = r_buf_full ? r_buf : IDLE_FILL;

    assign tx.tx_ready    = ~r_buf_full;
    assign tx.tx_done     = r_tx_done;
    assign tx.tx_underrun = r_underrun;
    assign busy           = (r_state == S_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_sync  <= 2'b11;
            r_sck_sync <= 2'b00;
        end else begin
            r_cs_sync  <= {r_cs_sync[0], spi_cs};
            r_sck_sync <= {r_sck_sync[0], spi_sck};
        end
    end

    // A load from an empty buffer and a handshake may coincide; the new byte survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf      <= 8'h00;
            r_buf_full <= 1'b0;
        end else begin
            if (w_load)
                r_buf_full <= 1'b0;
            if (w_hs) begin
                r_buf      <= tx.tx_data;
                r_buf_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shreg     <= 8'h00;
            r_bitcnt    <= 4'd0;
            r_done_pend <= 1'b0;
            r_tx_done   <= 1'b0;
            r_underrun  <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            r_done_pend <= 1'b0;
            r_tx_done   <= r_done_pend;
            r_underrun  <= w_load & ~r_buf_full;
            r_miso      <= (r_state == S_SHIFT) & ~w_cs_flag & r_shreg[7];
            case (r_state)
                S_IDLE: begin
                    r_bitcnt <= 4'd0;
                    if (w_cs_neg) begin
                        r_shreg <= w_load_byte;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_cs_flag) begin
                        // CS rise wins over any SCK edge; partial byte is dropped.
                        r_state  <= S_IDLE;
                        r_bitcnt <= 4'd0;
                    end else if (w_sck_pos) begin
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7)
                            r_done_pend <= 1'b1;
                    end else if (w_sck_neg) begin
                        if (r_bitcnt == 4'd8) begin
                            r_shreg  <= w_load_byte;
                            r_bitcnt <= 4'd0;
                        end else begin
                            r_shreg <= {r_shreg[6:0], 1'b0};
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SPI_TXD_HIZ_EN
    logic r_oe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_oe <= 1'b0;
        else
            r_oe <= (r_state == S_SHIFT) & ~w_cs_flag;
    end

    assign spi_miso = r_oe ? r_miso : 1'bz;
`else
    assign spi_miso = r_miso;
`endif

endmodule

// File: tb/tb_spi_slave_txd.sv
// Randomized bench for spi_slave_txd: a byte-level model predicts each transmitted
// byte and pulse count; a sampler acting as the SPI master checks bytes as they arrive.
module tb_spi_slave_txd;
    localparam logic [7:0] FILL = 8'hFF;

    logic clk = 1'b0;
    logic rst_n;
    logic spi_cs, spi_sck;
    logic spi_miso, busy;

    spi_slave_txd_if txif ();

    spi_slave_txd #(.IDLE_FILL(FILL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_cs   (spi_cs),
        .spi_sck  (spi_sck),
        .spi_miso (spi_miso),
        .busy     (busy),
        .tx       (txif)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    int done_cnt = 0, und_cnt = 0;
    int exp_done = 0, exp_und = 0;

    logic [7:0] buf_q[$];   // model of the holding buffer (0 or 1 entries)
    logic [7:0] exp_q[$];   // bytes the master should receive, in order
    bit         push_en[4];
    logic [7:0] push_d[4];
    bit         sim_en;
    logic [7:0] sim_d;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of a shift-register load: the buffered byte if any, else the fill byte.
    function automatic logic [7:0] model_load();
        if (buf_q.size() != 0)
            return buf_q.pop_front();
        exp_und++;
        return FILL;
    endfunction

    // Master side: sample MISO on each SCK rise, check every completed byte.
    int         rx_bits = 0;
    logic [7:0] rx_byte = 8'h00;
    always @(posedge spi_sck or posedge spi_cs) begin
        if (spi_cs) begin
            rx_bits = 0;
        end else begin
            rx_byte = {rx_byte[6:0], spi_miso};
            rx_bits++;
            if (rx_bits == 8) begin
                rx_bits = 0;
                if (exp_q.size() == 0)
                    cmp("rx_unexpected_byte", 32'(rx_byte), 32'hxx);
                else
                    cmp("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (txif.tx_done === 1'b1) done_cnt++;
        if (txif.tx_underrun === 1'b1) und_cnt++;
    end

    // Handshake one byte; called on a negedge, returns one clk later.
    task automatic push(input logic [7:0] d);
        if (buf_q.size() != 0) return;
        cmp("tx_ready_before_push", 32'(txif.tx_ready), 32'd1);
        txif.tx_valid = 1'b1;
        txif.tx_data  = d;
        buf_q.push_back(d);
        @(negedge clk);
        txif.tx_valid = 1'b0;
    endtask

    task automatic run_frame(input int nbytes, input int abort_cycles);
        logic [7:0] first, lb;
        bit aborted = 1'b0;
        spi_cs = 1'b0;
        first = model_load();
        exp_q.push_back(first);
        @(negedge clk);
        if (sim_en) begin
            txif.tx_valid = 1'b1;
            txif.tx_data  = sim_d;
        end
        @(negedge clk);
        txif.tx_valid = 1'b0;
        if (sim_en) buf_q.push_back(sim_d);
        cmp("miso_before_load", 32'(spi_miso), 32'd0);
        @(negedge clk);
        cmp("miso_first_bit", 32'(spi_miso), 32'(first[7]));
        repeat (3) @(negedge clk);
        for (int b = 0; b < nbytes && !aborted; b++) begin
            for (int k = 0; k < 8 && !aborted; k++) begin
                if (abort_cycles != 0 && b * 8 + k == abort_cycles) begin
                    aborted = 1'b1;
                end else begin
                    spi_sck = 1'b1;
                    if (k == 7) exp_done++;
                    if (k == 2 && push_en[b]) begin
                        push(push_d[b]);
                        repeat (7) @(negedge clk);
                    end else begin
                        repeat (8) @(negedge clk);
                    end
                    spi_sck = 1'b0;
                    if (k == 7) begin
                        lb = model_load();
                        if (b + 1 < nbytes) exp_q.push_back(lb);
                    end
                    repeat (8) @(negedge clk);
                end
            end
        end
        spi_cs = 1'b1;
        if (aborted) begin
            repeat (2) @(negedge clk);
            cmp("busy_2clk_after_cs_rise", 32'(busy), 32'd1);
            @(negedge clk);
            cmp("busy_3clk_after_cs_rise", 32'(busy), 32'd0);
            cmp("tx_ready_after_abort", 32'(txif.tx_ready), (buf_q.size() != 0) ? 32'd0 : 32'd1);
            exp_q.delete();
            repeat (3) @(negedge clk);
        end else begin
            repeat (6) @(negedge clk);
        end
        cmp("tx_done_count", 32'(done_cnt), 32'(exp_done));
        cmp("tx_underrun_count", 32'(und_cnt), 32'(exp_und));
        cmp("bytes_outstanding", 32'(exp_q.size()), 32'd0);
        cmp("busy_idle", 32'(busy), 32'd0);
        foreach (push_en[i]) push_en[i] = 1'b0;
        sim_en = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        spi_cs = 1'b1;
        spi_sck = 1'b0;
        txif.tx_valid = 1'b0;
        txif.tx_data = 8'h00;
        sim_en = 1'b0;
        sim_d = 8'h00;
        foreach (push_en[i]) begin push_en[i] = 1'b0; push_d[i] = 8'h00; end
        repeat (3) @(negedge clk);
        cmp("reset_miso", 32'(spi_miso), 32'd0);
        cmp("reset_tx_ready", 32'(txif.tx_ready), 32'd1);
        cmp("reset_busy", 32'(busy), 32'd0);
        cmp("reset_tx_done", 32'(txif.tx_done), 32'd0);
        cmp("reset_tx_underrun", 32'(txif.tx_underrun), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // single byte
        push(8'hA5);
        repeat (2) @(negedge clk);
        run_frame(1, 0);

        // streaming two bytes with mid-byte refill
        push(8'h3C);
        repeat (2) @(negedge clk);
        push_en[0] = 1'b1; push_d[0] = 8'hC3;
        run_frame(2, 0);

        // underrun from an empty buffer
        run_frame(1, 0);

        // abort after 4 SCK cycles with the next byte already buffered
        push(8'h81);
        repeat (2) @(negedge clk);
        push_en[0] = 1'b1; push_d[0] = 8'h5A;
        run_frame(1, 4);

        // drain the retained byte, then the simultaneous load/handshake case
        run_frame(1, 0);
        sim_en = 1'b1; sim_d = 8'h55;
        run_frame(2, 0);

        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                push(8'($urandom));
                repeat (2) @(negedge clk);
            end
            n = int'($urandom_range(1, 3));
            for (int b = 0; b < 4; b++) begin
                push_en[b] = ($urandom_range(0, 3) != 0);
                push_d[b]  = 8'($urandom);
            end
            run_frame(n, 0);
        end

        // reset mid-byte with the buffer full
        push(8'h11);
        repeat (2) @(negedge clk);
        spi_cs = 1'b0;
        exp_q.push_back(model_load());
        repeat (6) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            spi_sck = 1'b1;
            if (k == 1) begin push(8'h22); repeat (7) @(negedge clk); end
            else repeat (8) @(negedge clk);
            spi_sck = 1'b0;
            repeat (3) @(negedge clk);
        end
        cmp("tx_ready_full_before_reset", 32'(txif.tx_ready), 32'd0);
        cmp("busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        cmp("midrst_miso", 32'(spi_miso), 32'd0);
        cmp("midrst_tx_ready", 32'(txif.tx_ready), 32'd1);
        cmp("midrst_busy", 32'(busy), 32'd0);
        cmp("midrst_tx_done", 32'(txif.tx_done), 32'd0);
        cmp("midrst_tx_underrun", 32'(txif.tx_underrun), 32'd0);
        buf_q.delete();
        exp_q.delete();
        @(negedge clk);
        spi_cs = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // recovery after reset
        push(8'h96);
        repeat (2) @(negedge clk);
        run_frame(1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/spi_slave_txd.md
# spi_slave_txd

SPI slave transmitter that shifts bytes out on MISO, MSB first, in SPI mode 0 (CPOL=0, CPHA=0). The master samples on rising SCK edges, and this block updates MISO on falling SCK edges. It pairs with the slave-side MOSI receiver on the same `spi_cs`/`spi_sck` pins, with all SPI inputs oversampled in the `clk` domain. Bytes come from the local logic through a one-deep valid/ready buffer, so several bytes can stream back-to-back within one CS frame.

## Interface
- `IDLE_FILL`, default 8'hFF: byte transmitted when the buffer is empty at load time.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `spi_cs` in 1: chip select, active low, asynchronous to `clk`.
- `spi_sck` in 1: SPI clock, idle low, asynchronous to `clk`.
- `spi_miso` out 1: serial data to master.
- `tx_data` in 8: byte to transmit.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: holding buffer empty; a transfer occurs when `tx_valid` and `tx_ready` are both high.
- `tx_done` out 1: one-cycle pulse when the 8th bit of a byte has been sampled by the master.
- `tx_underrun` out 1: one-cycle pulse when `IDLE_FILL` was loaded because the buffer was empty.
- `busy` out 1: high while in SHIFT.

## Operation
- **Synchronizers.** `spi_cs` and `spi_sck` each pass through 2 flops.
  - Reset values: cs pair = 2'b11, sck pair = 2'b00.
  - `cs_neg` = s1 & ~s0.
  - `sck_pos` = ~s1 & s0.
  - `sck_neg` = s1 & ~s0.
  - `cs_flag` = s1.
- **Holding buffer.**
  - Filled on handshake.
  - Emptied when its content is loaded into the shift register.
  - `tx_ready` = ~buf_full.
- **Shift register.**
  - `shreg[7:0]` holds the byte in flight; `bitcnt[3:0]` counts 0..8.
  - MISO drives `shreg[7]`.
- **FSM, IDLE state.**
  - `busy`=0 and `bitcnt`=0.
  - On `cs_neg`: load `shreg` from the buffer if full, else from `IDLE_FILL` and pulse `tx_underrun`. Then go to SHIFT.
- **FSM, SHIFT state.**
  - If `cs_flag`=1, go to IDLE. A partial byte is discarded, with no `tx_done`. The buffer content is retained.
  - On `sck_pos`: `bitcnt`+1. When `bitcnt` becomes 8, pulse `tx_done`.
  - On `sck_neg` with `bitcnt`<8: `shreg` <= {shreg[6:0],1'b0}.
  - On `sck_neg` with `bitcnt`==8: reload `shreg` (buffer or fill, same rule as IDLE) and set `bitcnt` to 0. This gives a continuous multi-byte stream.
- **Simultaneous events.**
  - A handshake in the same cycle as a load from an empty buffer: the load uses `IDLE_FILL` (pulse `tx_underrun`), and the new byte is kept for the next byte.
  - A handshake in the same cycle as a load from a full buffer is impossible, because `tx_ready`=0.
  - `cs_flag`=1 takes priority over any SCK edge in the same cycle.
- **Reset mid-operation.** Everything returns to reset values immediately. The buffer is emptied.

## Timing
- **Reset values.**
  - `spi_miso`=0, `tx_ready`=1, `tx_done`=0, `tx_underrun`=0, `busy`=0.
  - `shreg`=0, `bitcnt`=0, state=IDLE.
- **CS fall to MISO.** The first bit (MSB) is valid 3 clk after `spi_cs` falls: 2 sync cycles plus 1 load cycle.
- **SCK fall to MISO.** The next bit is valid 3 clk after `spi_sck` falls.
- **Master constraints.**
  - SCK half-period ≥ 4 clk.
  - CS setup to the first SCK rise ≥ 4 clk.
  - CS high time ≥ 3 clk.
- **`tx_done`.** Asserted 3 clk after the 8th SCK rise.
- **Buffer refill.** `tx_ready` rises 1 clk after a load. The next byte must arrive before the next byte boundary's `sck_neg`, or an underrun occurs.

## Configuration
- `SPI_TXD_HIZ_EN` defined: `spi_miso` = 1'bz whenever `cs_flag`=1 or state=IDLE. This allows a shared MISO bus.
- `SPI_TXD_HIZ_EN` undefined: `spi_miso` is driven 0 whenever `cs_flag`=1 or state=IDLE. In SHIFT it always drives `shreg[7]`.

## Test plan
- **Single byte.**
  - Stimulus: load 8'hA5, then CS low with 8 SCK cycles (half-period 8 clk).
  - Response: the master samples 1,0,1,0,0,1,0,1 and sees one `tx_done`, with no `tx_underrun`.
- **Streaming.**
  - Stimulus: load 8'h3C, CS low, refill 8'hC3 after `tx_ready` rises, 16 SCK cycles.
  - Response: the master receives 0x3C then 0xC3, with 2 `tx_done` pulses.
- **Underrun.**
  - Stimulus: empty buffer, CS low, 8 SCK cycles.
  - Response: the master receives 0xFF, with `tx_underrun` pulsing once at CS fall and `tx_done` pulsing once.
- **Abort.**
  - Stimulus: load 8'h81, CS high after 4 SCK cycles.
  - Response: no `tx_done`; `busy` drops 3 clk after CS rise; `tx_ready`=0 (next byte already loaded into the buffer stays).
- **Simultaneous load and handshake.**
  - Stimulus: present `tx_valid` 8'h55 in the exact cycle of the CS-fall load while the buffer is empty.
  - Response: the first byte is 0xFF (underrun) and the second byte is 0x55.
- **Reset mid-byte.**
  - Stimulus: assert `rst_n`=0 after 3 SCK cycles.
  - Response: all outputs go to reset values asynchronously, with `tx_ready`=1.
